// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (I)
// and load/store (D); one access per LAT+2 cycles with a fixed-latency read return.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LAT    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [ADDR_W-3:0] m_addr,
  output logic [3:0]        m_wmask,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy,
  output logic              gnt_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [3:0]        wmask_r, wmask_nxt;
  logic              gnt_nxt;
  logic [ADDR_W-3:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gnt_d   <= 1'b1;
      m_addr  <= '0;
      m_wdata <= '0;
      wmask_r <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt_d   <= gnt_nxt;
      m_addr  <= addr_nxt;
      m_wdata <= wdata_nxt;
      wmask_r <= wmask_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_d;
    addr_nxt  = m_addr;
    wdata_nxt = m_wdata;
    wmask_nxt = wmask_r;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // D wins when alone, or on contention when I was served last
          gnt_nxt = d_req && (!i_req || !gnt_d);
          if (gnt_nxt) begin
            addr_nxt  = d_addr[ADDR_W-1:2];
            wdata_nxt = d_wdata;
            wmask_nxt = d_wmask;
          end else begin
            addr_nxt  = i_addr[ADDR_W-1:2];
            wdata_nxt = '0;
            wmask_nxt = '0;
          end
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = CNT_INIT;
        state_nxt = (LAT > 1) ? WAIT : DONE;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_en    = (state == ISSUE);
  assign m_wmask = m_en ? wmask_r : '0;
  assign busy    = (state != IDLE);
  assign i_done  = (state == DONE) && !gnt_d;
  assign d_done  = (state == DONE) && gnt_d;
  assign i_rdata = i_done ? m_rdata : '0;
  assign d_rdata = d_done ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LAT=1 and LAT=3), each with its own memory,
// checked against a transaction-level round-robin/memory model.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_req   [2];
  logic [31:0] i_addr  [2];
  logic        i_done  [2];
  logic [31:0] i_rdata [2];
  logic        d_req   [2];
  logic [31:0] d_addr  [2];
  logic [3:0]  d_wmask [2];
  logic [31:0] d_wdata [2];
  logic        d_done  [2];
  logic [31:0] d_rdata [2];
  logic        m_en    [2];
  logic [29:0] m_addr  [2];
  logic [3:0]  m_wmask [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        busy    [2];
  logic        gnt_d   [2];

  logic [31:0] mem     [2][16];
  logic [31:0] pipe    [2][3];
  logic [31:0] ref_mem [2][16];
  bit          last_d  [2];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .LAT(k == 0 ? 1 : 3)) u_dut (
      .CLK(CLK), .RST(RST),
      .i_req(i_req[k]), .i_addr(i_addr[k]), .i_done(i_done[k]), .i_rdata(i_rdata[k]),
      .d_req(d_req[k]), .d_addr(d_addr[k]), .d_wmask(d_wmask[k]), .d_wdata(d_wdata[k]),
      .d_done(d_done[k]), .d_rdata(d_rdata[k]),
      .m_en(m_en[k]), .m_addr(m_addr[k]), .m_wmask(m_wmask[k]), .m_wdata(m_wdata[k]),
      .m_rdata(m_rdata[k]), .busy(busy[k]), .gnt_d(gnt_d[k])
    );
    assign m_rdata[k] = pipe[k][(k == 0) ? 0 : 2];
  end

  function automatic logic [31:0] init_word(input int w);
    if (w == 2) return 32'h0010_8093;
    return 32'hA500_0000 ^ (32'(w) * 32'h0101_0101);
  endfunction

  // Memory: samples the strobe, writes by byte mask, returns the word LAT cycles later
  // (garbage in between so a mistimed capture shows up)
  always @(posedge CLK or posedge RST) begin
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        for (int w = 0; w < 16; w++) mem[k][w] <= init_word(w);
        for (int p = 0; p < 3; p++) pipe[k][p] <= '0;
      end else begin
        pipe[k][1] <= pipe[k][0];
        pipe[k][2] <= pipe[k][1];
        if (m_en[k]) begin
          pipe[k][0] <= mem[k][m_addr[k][3:0]];
          for (int b = 0; b < 4; b++)
            if (m_wmask[k][b]) mem[k][m_addr[k][3:0]][8*b +: 8] <= m_wdata[k][8*b +: 8];
        end else begin
          pipe[k][0] <= $urandom;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_d[k] = 1'b1;
      for (int w = 0; w < 16; w++) ref_mem[k][w] = init_word(w);
    end
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, "_busy"},  32'(busy[k]),   32'd0);
    check({tag, "_m_en"},  32'(m_en[k]),   32'd0);
    check({tag, "_wmask"}, 32'(m_wmask[k]), 32'd0);
    check({tag, "_addr"},  32'(m_addr[k]), 32'd0);
    check({tag, "_wdata"}, m_wdata[k],     32'd0);
    check({tag, "_idone"}, 32'(i_done[k]), 32'd0);
    check({tag, "_ddone"}, 32'(d_done[k]), 32'd0);
    check({tag, "_gnt"},   32'(gnt_d[k]),  32'd1);
  endtask

  // One granted access: called at a negedge in IDLE with requests already applied
  task automatic serve(input int k, input bit pd, input bit drop);
    int          lat;
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  wm;
    lat    = (k == 0) ? 1 : 3;
    a      = pd ? d_addr[k] : i_addr[k];
    wm     = pd ? d_wmask[k] : 4'h0;
    wd     = d_wdata[k];
    exp_rd = ref_mem[k][a[5:2]];
    for (int b = 0; b < 4; b++)
      if (wm[b]) ref_mem[k][a[5:2]][8*b +: 8] = wd[8*b +: 8];
    last_d[k] = pd;
    for (int c = 1; c <= lat + 2; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("busy", 32'(busy[k]), 32'(c <= lat + 1));
      check("m_en", 32'(m_en[k]), 32'(c == 1));
      check("i_done", 32'(i_done[k]), 32'(c == lat + 1 && !pd));
      check("d_done", 32'(d_done[k]), 32'(c == lat + 1 && pd));
      if (c == 1) begin
        check("m_addr", 32'(m_addr[k]), 32'(a[31:2]));
        check("m_wmask", 32'(m_wmask[k]), 32'(wm));
        check("gnt_d", 32'(gnt_d[k]), 32'(pd));
        if (pd) check("m_wdata", m_wdata[k], wd);
        if (drop) begin
          if (pd) begin
            d_req[k] = 1'b0; d_addr[k] = $urandom; d_wdata[k] = $urandom; d_wmask[k] = 4'($urandom);
          end else begin
            i_req[k] = 1'b0; i_addr[k] = $urandom;
          end
        end
      end else begin
        check("m_wmask_off", 32'(m_wmask[k]), 32'd0);
      end
      if (c == lat + 1) begin
        if (pd) begin
          check("d_rdata", d_rdata[k], exp_rd);
          check("i_rdata_off", i_rdata[k], 32'd0);
          d_req[k] = 1'b0;
        end else begin
          check("i_rdata", i_rdata[k], exp_rd);
          check("d_rdata_off", d_rdata[k], 32'd0);
          i_req[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_round(input int k, input bit ri, input bit rd, input logic [31:0] ia,
                          input logic [31:0] da, input logic [3:0] wm, input logic [31:0] wd,
                          input bit drop);
    bit first_d;
    i_req[k] = ri; i_addr[k] = ia;
    d_req[k] = rd; d_addr[k] = da; d_wmask[k] = wm; d_wdata[k] = wd;
    first_d = (ri && rd) ? !last_d[k] : rd;
    serve(k, first_d, drop);
    if (ri && rd) serve(k, !first_d, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sel;
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_addr[k] = '0;
      d_wmask[k] = '0; d_wdata[k] = '0;
    end
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst1");

    // continuous contention from reset: I, D, I, D
    do_round(0, 1, 1, 32'h0000_0000, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
    do_round(0, 1, 1, 32'h0000_0004, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
    // plain fetch of word 2
    do_round(0, 1, 0, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 1'b0);
    // partial store then fetch of the same word
    do_round(0, 0, 1, 32'h0, 32'h0000_000C, 4'b0011, 32'hDEAD_BEEF, 1'b0);
    do_round(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'h0, 1'b0);
    check("store_merge", ref_mem[0][3], {init_word(3)[31:16], 16'hBEEF});
    // request dropped and address changed right after grant
    do_round(0, 1, 0, 32'h0000_0014, 32'h0, 4'h0, 32'h0, 1'b1);
    // LAT=3 load
    do_round(1, 0, 1, 32'h0, 32'h0000_0004, 4'h0, 32'h0, 1'b0);

    // reset pulse during WAIT aborts with no done
    d_req[1] = 1'b1; d_addr[1] = 32'h0000_0010; d_wmask[1] = 4'h0;
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    check("pre_rst_busy", 32'(busy[1]), 32'd1);
    #1 RST = 1'b1;
    #1 check_idle_outputs(1, "arst");
    d_req[1] = 1'b0;
    #1 RST = 1'b0;
    model_reset();
    repeat (5) begin
      @(posedge CLK); @(negedge CLK);
      check("post_rst_ddone", 32'(d_done[1]), 32'd0);
      check("post_rst_busy", 32'(busy[1]), 32'd0);
    end
    do_round(1, 1, 0, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 1'b0);

    for (int r = 0; r < 60; r++) begin
      sel = $urandom_range(1, 3);
      do_round(r % 2, sel[0], sel[1], $urandom, $urandom,
               ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom,
               $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
